dmem_arbiter: RTL and testbench

Shares the single-port data RAM (12-bit address, 32-bit word, 1-cycle synchronous read) between the processor data port and one peripheral requester, such as the audio/VGA score logic. The processor cannot stall, so it always has absolute priority. The peripheral is served in idle RAM cycles through a req/gnt handshake with tagged read return. A starvation monitor and a grant counter are exposed for debug on the 7-segment display.

---
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: the processor always owns the RAM when it is busy; one peripheral
// requester is served in idle cycles with a req/gnt handshake and tagged read return.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wren,
    input  logic              cpu_rden,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              periph_req,
    input  logic              periph_we,
    input  logic [ADDR_W-1:0] periph_addr,
    input  logic [DATA_W-1:0] periph_wdata,
    output logic              periph_gnt,
    output logic              periph_rvalid,
    output logic [DATA_W-1:0] periph_rdata,
    output logic              periph_starved,
    output logic [15:0]       grant_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_q, state_nxt;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_nxt;
    logic              starved_q, starved_nxt;
    logic              rd_tag_q;
    logic [DATA_W-1:0] hold_q;
    logic [15:0]       grant_cnt_q;
    logic              cpu_busy;
    logic              gnt;

    assign cpu_busy = cpu_wren | cpu_rden;
    // Reset gates the grant so nothing reaches the RAM while held in reset.
    assign gnt      = periph_req & ~cpu_busy & reset;

    always_comb begin
        ram_addr = cpu_addr;
        ram_wen  = 1'b0;
        ram_din  = cpu_wdata;
        if (cpu_busy) begin
            ram_wen = cpu_wren;
        end else if (periph_req) begin
            ram_addr = periph_addr;
            ram_wen  = periph_we;
            ram_din  = periph_wdata;
        end
        ram_wen = ram_wen & reset;
    end

    always_comb begin
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        case (state_q)
            ST_IDLE: if (periph_req & cpu_busy) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (gnt | ~periph_req) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt_q != LIMIT) begin
                    wait_cnt_nxt = wait_cnt_q + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Sticky until the peripheral finally gets through.
        starved_nxt = gnt ? 1'b0 : (starved_q | (wait_cnt_nxt == LIMIT));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            starved_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
            hold_q      <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            starved_q  <= starved_nxt;
            rd_tag_q   <= gnt & ~periph_we;
            if (rd_tag_q) hold_q <= ram_dout;
            if (gnt) grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign cpu_rdata      = ram_dout;
    assign periph_gnt     = gnt;
    assign periph_rvalid  = rd_tag_q;
    assign periph_rdata   = rd_tag_q ? ram_dout : hold_q;
    assign periph_starved = starved_q;
    assign grant_count    = grant_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, a golden-memory reference model, a mux table,
// hand-written corner sequences and randomized traffic.
module tb_dmem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr, periph_addr, ram_addr;
    logic          cpu_wren, cpu_rden, periph_req, periph_we;
    logic [DW-1:0] cpu_wdata, cpu_rdata, periph_wdata, periph_rdata, ram_din, ram_dout;
    logic          periph_gnt, periph_rvalid, periph_starved, ram_wen;
    logic [15:0]   grant_count;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_rden(cpu_rden),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .periph_req(periph_req), .periph_we(periph_we), .periph_addr(periph_addr),
        .periph_wdata(periph_wdata), .periph_gnt(periph_gnt), .periph_rvalid(periph_rvalid),
        .periph_rdata(periph_rdata), .periph_starved(periph_starved),
        .grant_count(grant_count), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // Single-port RAM, 1-cycle synchronous read.
    logic [DW-1:0] mem [0:4095];
    always @(posedge clock) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the RAM each cycle, what the memory holds, and how long
    // the peripheral has been blocked.
    logic [DW-1:0] gold [0:4095];
    logic          m_rd_pend, m_cpu_pend, m_starved;
    logic [DW-1:0] m_rd_data, m_hold, m_cpu_data;
    logic [15:0]   m_gc;
    int            m_run;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd_pend = 0; m_cpu_pend = 0; m_starved = 0;
        m_hold = '0; m_rd_data = '0; m_cpu_data = '0; m_gc = '0; m_run = 0;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic rq, input logic pwe,
                        input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        logic busy, eg, ew;
        logic [AW-1:0] ea;
        cpu_wren = wr; cpu_rden = rd; cpu_addr = ca; cpu_wdata = cd;
        periph_req = rq; periph_we = pwe; periph_addr = pa; periph_wdata = pd;
        #2;
        busy = wr | rd;
        eg   = rq & ~busy;
        ew   = busy ? wr : (rq & pwe);
        ea   = (!busy && rq) ? pa : ca;
        chk("gnt", {31'b0, periph_gnt}, {31'b0, eg});
        chk("ram_wen", {31'b0, ram_wen}, {31'b0, ew});
        chk("ram_addr", {20'b0, ram_addr}, {20'b0, ea});
        if (ew) chk("ram_din", ram_din, busy ? cd : pd);
        chk("rvalid", {31'b0, periph_rvalid}, {31'b0, m_rd_pend});
        chk("periph_rdata", periph_rdata, m_rd_pend ? m_rd_data : m_hold);
        chk("starved", {31'b0, periph_starved}, {31'b0, m_starved});
        chk("grant_count", {16'b0, grant_count}, {16'b0, m_gc});
        if (m_cpu_pend) chk("cpu_rdata", cpu_rdata, m_cpu_data);
        if (m_rd_pend) m_hold = m_rd_data;
        m_rd_pend = eg & ~pwe;
        if (m_rd_pend) m_rd_data = gold[pa];
        m_cpu_pend = rd & ~wr;
        m_cpu_data = gold[ca];
        if (busy && wr) gold[ca] = cd;
        else if (eg && pwe) gold[pa] = pd;
        m_run = (rq && busy) ? m_run + 1 : 0;
        if (eg) m_starved = 0;
        else if (m_run - 1 >= SL) m_starved = 1;
        if (eg) m_gc = m_gc + 16'd1;
        @(posedge clock); #1;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    typedef struct {
        logic wr, rd, rq, pwe;
        logic e_gnt, e_wen, e_periph;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin mem[i] = '0; gold[i] = '0; end
        model_reset();
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 1, 0, 1};
        tbl[2] = '{0, 0, 1, 1, 1, 1, 1};
        tbl[3] = '{1, 0, 1, 1, 0, 1, 0};
        tbl[4] = '{0, 1, 1, 1, 0, 0, 0};
        tbl[5] = '{1, 1, 0, 0, 0, 1, 0};
        tbl[6] = '{1, 1, 1, 0, 0, 1, 0};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 0};

        // Reset state, with a peripheral write request present to prove gating.
        reset = 0;
        cpu_wren = 0; cpu_rden = 0; cpu_addr = '0; cpu_wdata = '0;
        periph_req = 1; periph_we = 1; periph_addr = 12'h055; periph_wdata = 32'h1234;
        #3;
        chk("rst_gnt", {31'b0, periph_gnt}, 32'd0);
        chk("rst_wen", {31'b0, ram_wen}, 32'd0);
        chk("rst_rvalid", {31'b0, periph_rvalid}, 32'd0);
        chk("rst_rdata", periph_rdata, 32'd0);
        chk("rst_starved", {31'b0, periph_starved}, 32'd0);
        chk("rst_gc", {16'b0, grant_count}, 32'd0);
        periph_req = 0; periph_we = 0;
        @(posedge clock); #1;
        reset = 1;

        // Test 2: peripheral write then read back.
        step(0, 0, '0, '0, 1, 1, 12'h010, 32'hDEADBEEF);
        step(0, 0, '0, '0, 1, 0, 12'h010, '0);
        chk("t2_rvalid", {31'b0, periph_rvalid}, 32'd1);
        chk("t2_rdata", periph_rdata, 32'hDEADBEEF);
        chk("t2_gc", {16'b0, grant_count}, 32'd2);
        idle(); idle();
        chk("t2_hold", periph_rdata, 32'hDEADBEEF);

        // Mux/grant table.
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] d;
            d = $urandom;
            cpu_wren = tbl[i].wr; cpu_rden = tbl[i].rd; cpu_addr = 12'h0AA; cpu_wdata = d;
            periph_req = tbl[i].rq; periph_we = tbl[i].pwe; periph_addr = 12'h055; periph_wdata = ~d;
            #1;
            chk($sformatf("tbl%0d_gnt", i), {31'b0, periph_gnt}, {31'b0, tbl[i].e_gnt});
            chk($sformatf("tbl%0d_wen", i), {31'b0, ram_wen}, {31'b0, tbl[i].e_wen});
            chk($sformatf("tbl%0d_addr", i), {20'b0, ram_addr},
                {20'b0, tbl[i].e_periph ? 12'h055 : 12'h0AA});
            step(tbl[i].wr, tbl[i].rd, 12'h0AA, d, tbl[i].rq, tbl[i].pwe, 12'h055, ~d);
        end
        idle(); idle();

        // Test 3: five blocked cycles, then the read sees the CPU's last store.
        for (int i = 0; i < 5; i++) step(1, 0, 12'h020, 32'hC0DE0000 + i, 1, 0, 12'h020, '0);
        step(0, 0, '0, '0, 1, 0, 12'h020, '0);
        chk("t3_rvalid", {31'b0, periph_rvalid}, 32'd1);
        chk("t3_rdata", periph_rdata, 32'hC0DE0004);
        idle();

        // Test 4: long starvation, sticky flag, cleared after the grant.
        for (int i = 0; i < 10; i++) step(0, 1, 12'h100, '0, 1, 1, 12'h200, 32'h5A5A);
        chk("t4_starved_hi", {31'b0, periph_starved}, 32'd1);
        step(0, 0, '0, '0, 1, 1, 12'h200, 32'h5A5A);
        chk("t4_starved_lo", {31'b0, periph_starved}, 32'd0);
        idle();

        // Test 5: peripheral read directly followed by a CPU load.
        step(1, 0, 12'h030, 32'h30303030, 0, 0, '0, '0);
        step(1, 0, 12'h040, 32'h40404040, 0, 0, '0, '0);
        step(0, 0, '0, '0, 1, 0, 12'h040, '0);
        step(0, 1, 12'h030, '0, 0, 0, '0, '0);
        chk("t5_cpu_rdata", cpu_rdata, 32'h30303030);
        chk("t5_hold", periph_rdata, 32'h40404040);
        idle();

        // Test 6: reset in the read-tag cycle discards the return.
        step(0, 0, '0, '0, 1, 0, 12'h010, '0);
        chk("t6_tag", {31'b0, periph_rvalid}, 32'd1);
        periph_req = 1; periph_we = 1;
        reset = 0;
        #1;
        chk("t6_rvalid", {31'b0, periph_rvalid}, 32'd0);
        chk("t6_gc", {16'b0, grant_count}, 32'd0);
        chk("t6_rdata", periph_rdata, 32'd0);
        chk("t6_gnt", {31'b0, periph_gnt}, 32'd0);
        chk("t6_wen", {31'b0, ram_wen}, 32'd0);
        @(posedge clock); #1;
        reset = 1;
        model_reset();
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic wr, rd, rq;
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) == 0);
            rq = ($urandom_range(0, 3) != 0);
            step(wr, rd, 12'($urandom_range(0, 15)), $urandom, rq, 1'($urandom),
                 12'($urandom_range(0, 15)), $urandom);
        end
        idle();

        // Grant counter wrap: 65536 grants from a known count return to the same value.
        begin
            logic [15:0] start;
            start = m_gc;
            for (int i = 0; i < 65536; i++) step(0, 0, '0, '0, 1, 1, 12'h300, 32'($unsigned(i)));
            chk("wrap_gc", {16'b0, grant_count}, {16'b0, start});
        end
        reset = 0; #1; reset = 1;
        model_reset();
        for (int i = 0; i < 65536; i++) step(0, 0, '0, '0, 1, 1, 12'h301, '0);
        chk("wrap_zero", {16'b0, grant_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
